// File: rtl/set_pkg.sv
// Shared types and widths for the SET command initiator.
// Mode codes, field widths, queued command layout and FSM states.
package set_pkg;

   localparam int CENTRAL_W = 24;
   localparam int RADIUS_W  = 12;
   localparam int CAND_W    = 8;

   localparam logic [1:0] MODE_A   = 2'd0;
   localparam logic [1:0] MODE_AND = 2'd1;
   localparam logic [1:0] MODE_XOR = 2'd2;
   localparam logic [1:0] MODE_TWO = 2'd3;

   typedef struct packed {
      logic [CENTRAL_W-1:0] central;
      logic [RADIUS_W-1:0]  radius;
      logic [1:0]           mode;
   } cmd_t;

   localparam int CMD_W = $bits(cmd_t);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_DONE
   } state_t;

endpackage

// File: rtl/set_host_if.sv
// Command and result handshakes between the system and set_host.
// master = command source / result sink, slave = set_host.
interface set_host_if;
   import set_pkg::*;

   logic                 cmd_valid;
   logic                 cmd_ready;
   logic [CENTRAL_W-1:0] cmd_central;
   logic [RADIUS_W-1:0]  cmd_radius;
   logic [1:0]           cmd_mode;

   logic                 res_valid;
   logic                 res_ready;
   logic [CAND_W-1:0]    res_candidate;
   logic [1:0]           res_mode;
   logic                 res_timeout;

   modport master (
      output cmd_valid, cmd_central, cmd_radius, cmd_mode, res_ready,
      input  cmd_ready, res_valid, res_candidate, res_mode, res_timeout
   );

   modport slave (
      input  cmd_valid, cmd_central, cmd_radius, cmd_mode, res_ready,
      output cmd_ready, res_valid, res_candidate, res_mode, res_timeout
   );

endinterface

// File: rtl/set_cmd_fifo.sv
// Generic synchronous FIFO, power-of-two depth, wrap-bit pointers.
// Read data is the current head; pop advances it.
module set_cmd_fifo #(
   parameter int WIDTH = 38,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty = (wr_ptr_q == rd_ptr_q);

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // storage needs no reset: the pointers define what is valid
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/set_host.sv
// Queues circle-set queries, issues them to SET one at a time and
// returns each count (or a watchdog error) on the result handshake.
module set_host
   import set_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 1023
) (
   input  logic                 clk,
   input  logic                 rst,
   set_host_if.slave            host,
   output logic                 set_en,
   output logic [CENTRAL_W-1:0] set_central,
   output logic [RADIUS_W-1:0]  set_radius,
   output logic [1:0]           set_mode,
   input  logic                 set_busy,
   input  logic                 set_valid,
   input  logic [CAND_W-1:0]    set_candidate
);

   localparam int WD_W = $clog2(TIMEOUT + 1);

   cmd_t fifo_wdata, fifo_rdata;
   logic fifo_full, fifo_empty;
   logic push, pop;

   state_t               state_q, state_d;
   logic                 set_en_q, set_en_d;
   logic [CENTRAL_W-1:0] set_central_q, set_central_d;
   logic [RADIUS_W-1:0]  set_radius_q, set_radius_d;
   logic [1:0]           set_mode_q, set_mode_d;
   logic                 res_valid_q, res_valid_d;
   logic [CAND_W-1:0]    res_cand_q, res_cand_d;
   logic [1:0]           res_mode_q, res_mode_d;
   logic                 res_timeout_q, res_timeout_d;
   logic [WD_W-1:0]      wdog_q, wdog_d;

   assign host.cmd_ready = !fifo_full && !rst;
   assign push = host.cmd_valid && host.cmd_ready;

   assign fifo_wdata.central = host.cmd_central;
   assign fifo_wdata.radius  = host.cmd_radius;
   assign fifo_wdata.mode    = host.cmd_mode;

   set_cmd_fifo #(
      .WIDTH (CMD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata (fifo_wdata),
      .pop   (pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      state_d       = state_q;
      set_en_d      = 1'b0;
      set_central_d = set_central_q;
      set_radius_d  = set_radius_q;
      set_mode_d    = set_mode_q;
      res_valid_d   = res_valid_q;
      res_cand_d    = res_cand_q;
      res_mode_d    = res_mode_q;
      res_timeout_d = res_timeout_q;
      wdog_d        = wdog_q;
      pop           = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (!fifo_empty && !set_busy) begin
               pop           = 1'b1;
               set_central_d = fifo_rdata.central;
               set_radius_d  = fifo_rdata.radius;
               set_mode_d    = fifo_rdata.mode;
               set_en_d      = 1'b1;
               wdog_d        = '0;
               state_d       = S_ISSUE;
            end
         end
         // the issue cycle itself counts toward the watchdog
         S_ISSUE: begin
            wdog_d  = WD_W'(1);
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (set_valid) begin
               res_cand_d    = set_candidate;
               res_timeout_d = 1'b0;
               res_mode_d    = set_mode_q;
               res_valid_d   = 1'b1;
               state_d       = S_DONE;
            end else if (wdog_q == WD_W'(TIMEOUT)) begin
               res_cand_d    = '0;
               res_timeout_d = 1'b1;
               res_mode_d    = set_mode_q;
               res_valid_d   = 1'b1;
               state_d       = S_DONE;
            end else begin
               wdog_d = wdog_q + WD_W'(1);
            end
         end
         S_DONE: begin
            if (host.res_ready) begin
               res_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         set_en_q      <= 1'b0;
         set_central_q <= '0;
         set_radius_q  <= '0;
         set_mode_q    <= '0;
         res_valid_q   <= 1'b0;
         res_cand_q    <= '0;
         res_mode_q    <= '0;
         res_timeout_q <= 1'b0;
         wdog_q        <= '0;
      end else begin
         state_q       <= state_d;
         set_en_q      <= set_en_d;
         set_central_q <= set_central_d;
         set_radius_q  <= set_radius_d;
         set_mode_q    <= set_mode_d;
         res_valid_q   <= res_valid_d;
         res_cand_q    <= res_cand_d;
         res_mode_q    <= res_mode_d;
         res_timeout_q <= res_timeout_d;
         wdog_q        <= wdog_d;
      end
   end

   assign set_en             = set_en_q;
   assign set_central        = set_central_q;
   assign set_radius         = set_radius_q;
   assign set_mode           = set_mode_q;
   assign host.res_valid     = res_valid_q;
   assign host.res_candidate = res_cand_q;
   assign host.res_mode      = res_mode_q;
   assign host.res_timeout   = res_timeout_q;

endmodule

// File: tb/tb_set_host.sv
// Scoreboard bench for set_host with a behavioural SET responder.
// Directed commands carry hand-computed candidate counts.
module tb_set_host;
   import set_pkg::*;

   localparam int TIMEOUT = 1023;
   localparam int LAT     = 6;

   typedef struct packed {
      logic [7:0] cand;
      logic [1:0] mode;
      logic       to;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        set_en;
   logic [23:0] set_central;
   logic [11:0] set_radius;
   logic [1:0]  set_mode;
   logic        set_busy;
   logic        set_valid;
   logic [7:0]  set_candidate;

   set_host_if hif ();

   set_host #(
      .FIFO_DEPTH (4),
      .TIMEOUT    (TIMEOUT)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .host          (hif),
      .set_en        (set_en),
      .set_central   (set_central),
      .set_radius    (set_radius),
      .set_mode      (set_mode),
      .set_busy      (set_busy),
      .set_valid     (set_valid),
      .set_candidate (set_candidate)
   );

   always #5 clk = ~clk;

   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   exp_t sb[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   function automatic int sq(input int v);
      return v * v;
   endfunction

   function automatic logic [7:0] set_count(input logic [23:0] c,
                                            input logic [11:0] r,
                                            input logic [1:0]  m);
      int  n;
      bit  a, b, k, hit;
      n = 0;
      for (int x = 0; x < 16; x++) begin
         for (int y = 0; y < 16; y++) begin
            a = (sq(x - int'(c[23:20])) + sq(y - int'(c[19:16])))
                <= sq(int'(r[11:8]));
            b = (sq(x - int'(c[15:12])) + sq(y - int'(c[11:8])))
                <= sq(int'(r[7:4]));
            k = (sq(x - int'(c[7:4])) + sq(y - int'(c[3:0])))
                <= sq(int'(r[3:0]));
            case (m)
               2'd0:    hit = a;
               2'd1:    hit = a && b;
               2'd2:    hit = a ^ b;
               default: hit = (int'(a) + int'(b) + int'(k)) == 2;
            endcase
            if (hit) n++;
         end
      end
      return 8'(n);
   endfunction

   // behavioural SET: latches one cycle after en, busy, then valid
   logic        m_arm, m_busy, m_valid;
   int          m_cnt;
   logic [7:0]  m_cand;
   logic [23:0] m_c;
   logic [11:0] m_r;
   logic [1:0]  m_m;
   logic        silent = 1'b0;
   logic        force_busy = 1'b0;

   assign set_busy      = m_busy | force_busy;
   assign set_valid     = m_valid;
   assign set_candidate = m_cand;

   always @(posedge clk) begin
      if (rst) begin
         m_arm   <= 1'b0;
         m_busy  <= 1'b0;
         m_valid <= 1'b0;
         m_cnt   <= 0;
         m_cand  <= '0;
      end else begin
         m_valid <= 1'b0;
         if (set_en) m_arm <= 1'b1;
         if (m_arm) begin
            m_arm  <= 1'b0;
            m_c    <= set_central;
            m_r    <= set_radius;
            m_m    <= set_mode;
            m_busy <= 1'b1;
            m_cnt  <= LAT;
         end else if (m_busy) begin
            if (m_cnt == 0) begin
               m_busy <= 1'b0;
               if (!silent) begin
                  m_valid <= 1'b1;
                  m_cand  <= set_count(m_c, m_r, m_m);
               end
            end else begin
               m_cnt <= m_cnt - 1;
            end
         end
      end
   end

   // monitor: scoreboard pops, result latency, issue spacing
   logic prev_en = 1'b0;
   logic rv_pend = 1'b0;
   logic have_v  = 1'b0;
   int   rv_cyc, last_v;
   exp_t e;

   always @(negedge clk) begin
      if (rst) begin
         rv_pend = 1'b0;
         have_v  = 1'b0;
         prev_en = 1'b0;
      end else begin
         if (rv_pend && cyc == rv_cyc) begin
            check("res_latency", 32'(hif.res_valid), 32'd1);
            rv_pend = 1'b0;
         end
         if (set_valid) begin
            check("hold_central", 32'(set_central), 32'(m_c));
            check("hold_radius", 32'(set_radius), 32'(m_r));
            rv_pend = 1'b1;
            rv_cyc  = cyc + 1;
            last_v  = cyc;
            have_v  = 1'b1;
         end
         if (set_en) begin
            check("en_pulse", 32'(prev_en), 32'd0);
            if (have_v) check("en_spacing", 32'(cyc - last_v >= 2), 32'd1);
         end
         prev_en = set_en;
         if (hif.res_valid && hif.res_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_result", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               check("res_candidate", 32'(hif.res_candidate), 32'(e.cand));
               check("res_mode", 32'(hif.res_mode), 32'(e.mode));
               check("res_timeout", 32'(hif.res_timeout), 32'(e.to));
            end
         end
      end
   end

   task automatic send(input logic [23:0] c, input logic [11:0] r,
                       input logic [1:0] m, input logic [7:0] ec,
                       input logic et, input bit track, output int hs);
      int n;
      @(posedge clk);
      #1;
      hif.cmd_valid   = 1'b1;
      hif.cmd_central = c;
      hif.cmd_radius  = r;
      hif.cmd_mode    = m;
      n = 0;
      @(negedge clk);
      while (!hif.cmd_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      hs = cyc;
      if (!hif.cmd_ready) check("cmd_accept", 32'd0, 32'd1);
      else if (track) sb.push_back('{cand: ec, mode: m, to: et});
      @(posedge clk);
      #1;
      hif.cmd_valid = 1'b0;
   endtask

   task automatic wait_en(output int ec);
      int n;
      n = 0;
      @(negedge clk);
      while (!set_en && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (!set_en) check("set_en_seen", 32'd0, 32'd1);
      ec = cyc;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      @(negedge clk);
      while ((sb.size() != 0 || hif.res_valid) && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check("drain", 32'(sb.size()), 32'd0);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_set_en"}, 32'(set_en), 32'd0);
      check({tag, "_set_central"}, 32'(set_central), 32'd0);
      check({tag, "_set_radius"}, 32'(set_radius), 32'd0);
      check({tag, "_set_mode"}, 32'(set_mode), 32'd0);
      check({tag, "_res_valid"}, 32'(hif.res_valid), 32'd0);
      check({tag, "_res_cand"}, 32'(hif.res_candidate), 32'd0);
      check({tag, "_res_mode"}, 32'(hif.res_mode), 32'd0);
      check({tag, "_res_to"}, 32'(hif.res_timeout), 32'd0);
   endtask

   int  hs, ec, lc, n;
   bit  saw;

   initial begin
      hif.cmd_valid   = 1'b0;
      hif.cmd_central = '0;
      hif.cmd_radius  = '0;
      hif.cmd_mode    = '0;
      hif.res_ready   = 1'b0;

      // reset state
      repeat (2) @(negedge clk);
      check("rst_cmd_ready", 32'(hif.cmd_ready), 32'd0);
      check_reset_vals("rst");
      @(posedge clk);
      #1;
      rst = 1'b0;
      hif.res_ready = 1'b1;

      // single query and launch latency
      send(24'h440000, 12'h200, MODE_A, 8'd13, 1'b0, 1'b1, hs);
      wait_en(ec);
      check("launch_latency", 32'(ec - hs), 32'd2);
      wait_drain();

      // mode coverage, back to back
      send(24'h444400, 12'h220, MODE_AND, 8'd13, 1'b0, 1'b1, hs);
      send(24'h444400, 12'h220, MODE_XOR, 8'd0, 1'b0, 1'b1, hs);
      send(24'h445400, 12'h220, MODE_AND, 8'd8, 1'b0, 1'b1, hs);
      send(24'h445400, 12'h220, MODE_XOR, 8'd10, 1'b0, 1'b1, hs);
      send(24'h445400, 12'h220, MODE_TWO, 8'd8, 1'b0, 1'b1, hs);
      send(24'h440000, 12'h300, MODE_A, 8'd29, 1'b0, 1'b1, hs);
      wait_drain();

      // full FIFO with result backpressure
      hif.res_ready = 1'b0;
      send(24'h440000, 12'h200, MODE_A, 8'd13, 1'b0, 1'b1, hs);
      send(24'h444400, 12'h220, MODE_AND, 8'd13, 1'b0, 1'b1, hs);
      send(24'h444400, 12'h220, MODE_XOR, 8'd0, 1'b0, 1'b1, hs);
      send(24'h445400, 12'h220, MODE_TWO, 8'd8, 1'b0, 1'b1, hs);
      send(24'h440000, 12'h300, MODE_A, 8'd29, 1'b0, 1'b1, hs);
      repeat (20) @(negedge clk);
      check("full_cmd_ready", 32'(hif.cmd_ready), 32'd0);
      check("full_res_valid", 32'(hif.res_valid), 32'd1);
      check("full_res_cand", 32'(hif.res_candidate), 32'd13);
      @(posedge clk);
      #1;
      hif.res_ready = 1'b1;
      wait_drain();

      // watchdog
      silent = 1'b1;
      send(24'h440000, 12'h200, MODE_XOR, 8'd0, 1'b1, 1'b1, hs);
      wait_en(ec);
      n = 0;
      @(negedge clk);
      while (!hif.res_valid && n < TIMEOUT + 200) begin
         @(negedge clk);
         n++;
      end
      check("wdog_latency", 32'(cyc - ec), 32'(TIMEOUT + 1));
      wait_drain();
      silent = 1'b0;
      send(24'h440000, 12'h200, MODE_A, 8'd13, 1'b0, 1'b1, hs);
      wait_drain();

      // reset while waiting with two commands queued
      silent = 1'b1;
      send(24'h440000, 12'h200, MODE_A, 8'd0, 1'b0, 1'b0, hs);
      wait_en(ec);
      send(24'h444400, 12'h220, MODE_AND, 8'd0, 1'b0, 1'b0, hs);
      send(24'h444400, 12'h220, MODE_XOR, 8'd0, 1'b0, 1'b0, hs);
      while (cyc < ec + 100) @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      check("midrst_cmd_ready", 32'(hif.cmd_ready), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      silent = 1'b0;
      @(negedge clk);
      check_reset_vals("midrst");
      check("midrst_ready_after", 32'(hif.cmd_ready), 32'd1);
      saw = 1'b0;
      repeat (8) begin
         @(negedge clk);
         saw |= set_en;
      end
      check("midrst_fifo_empty", 32'(saw), 32'd0);
      send(24'h440000, 12'h200, MODE_A, 8'd13, 1'b0, 1'b1, hs);
      wait_drain();

      // busy gating
      @(posedge clk);
      #1;
      force_busy = 1'b1;
      send(24'h444400, 12'h220, MODE_AND, 8'd13, 1'b0, 1'b1, hs);
      saw = 1'b0;
      repeat (20) begin
         @(negedge clk);
         saw |= set_en;
      end
      lc = cyc;
      check("busy_no_en", 32'(saw), 32'd0);
      @(posedge clk);
      #1;
      force_busy = 1'b0;
      wait_en(ec);
      check("busy_release_lat", 32'(ec - lc), 32'd2);
      wait_drain();

      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
